// File: rtl/antitheft_pkg.sv
// Shared encodings for the anti-theft controller: interval selectors, default
// delays and the timer state encoding.
package antitheft_pkg;

  localparam int TIME_W = 4;

  typedef enum logic [1:0] {
    ARM       = 2'b00,
    DRIVER    = 2'b01,
    PASSENGER = 2'b10,
    ALARM     = 2'b11
  } interval_e;

  localparam int DEF_T_ARM       = 6;
  localparam int DEF_T_DRIVER    = 8;
  localparam int DEF_T_PASSENGER = 15;
  localparam int DEF_T_ALARM     = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } timer_state_e;

  // A zero-second delay would never expire, so it is promoted to one second.
  function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] value);
    return (value == '0) ? TIME_W'(1) : value;
  endfunction

endpackage

// File: rtl/one_hz_divider.sv
// Free-running divider producing a single-cycle tick once per CLK_FREQ_HZ cycles.
// The tick is high while the counter sits at its terminal value.
module one_hz_divider #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_FREQ_HZ - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (r_count == CNT_MAX) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign tick = (r_count == CNT_MAX);

endmodule

// File: rtl/antitheft_timer.sv
// Programmable seconds timer for the anti-theft FSM: parameter store, 1 Hz
// divider and a down-counter that pulses expired on reaching zero.
//   state    | meaning
//   ST_IDLE  | not counting, remaining = 0
//   ST_COUNT | decrementing remaining on each 1 Hz tick
//   ST_DONE  | single cycle with expired = 1
module antitheft_timer
  import antitheft_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 50_000_000,
  parameter int T_ARM_DEF       = DEF_T_ARM,
  parameter int T_DRIVER_DEF    = DEF_T_DRIVER,
  parameter int T_PASSENGER_DEF = DEF_T_PASSENGER,
  parameter int T_ALARM_DEF     = DEF_T_ALARM
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reprogram,
  input  logic [1:0]        time_param_sel,
  input  logic [TIME_W-1:0] time_value,
  input  logic [1:0]        interval,
  input  logic              start_timer,
  output logic              expired,
  output logic              one_hz_enable,
  output logic [TIME_W-1:0] remaining
);

  logic [TIME_W-1:0] r_times [4];
  timer_state_e      r_state;
  logic [TIME_W-1:0] r_remaining;
  logic              r_expired;

  logic w_start_accepted;
  logic w_tick;

  // A write takes the whole cycle, so a coincident start is dropped.
  assign w_start_accepted = start_timer & ~reprogram;

  one_hz_divider #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_divider (
    .clock(clock),
    .reset(reset),
    .clear(w_start_accepted),
    .tick (w_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_times[ARM]       <= TIME_W'(T_ARM_DEF);
      r_times[DRIVER]    <= TIME_W'(T_DRIVER_DEF);
      r_times[PASSENGER] <= TIME_W'(T_PASSENGER_DEF);
      r_times[ALARM]     <= TIME_W'(T_ALARM_DEF);
    end else if (reprogram) begin
      r_times[time_param_sel] <= clamp_time(time_value);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || reprogram) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_expired   <= 1'b0;
    end else if (w_start_accepted) begin
      r_state     <= ST_COUNT;
      r_remaining <= r_times[interval];
      r_expired   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_remaining <= '0;
          r_expired   <= 1'b0;
        end
        ST_COUNT: begin
          r_expired <= 1'b0;
          if (w_tick) begin
            // <= 1 also catches a zero load from a zero default time
            if (r_remaining <= TIME_W'(1)) begin
              r_state     <= ST_DONE;
              r_remaining <= '0;
              r_expired   <= 1'b1;
            end else begin
              r_remaining <= r_remaining - TIME_W'(1);
            end
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_remaining <= '0;
          r_expired   <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_remaining <= '0;
          r_expired   <= 1'b0;
        end
      endcase
    end
  end

  assign expired       = r_expired;
  assign remaining     = r_remaining;
  assign one_hz_enable = w_tick;

endmodule

// File: tb/tb_antitheft_timer.sv
// Directed bench for antitheft_timer at CLK_FREQ_HZ=4: one second = 4 edges.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_antitheft_timer;

  logic       clock;
  logic       reset;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic [1:0] interval;
  logic       start_timer;
  logic       expired;
  logic       one_hz_enable;
  logic [3:0] remaining;

  int total = 0;
  int bad   = 0;

  antitheft_timer #(
    .CLK_FREQ_HZ(4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .reprogram     (reprogram),
    .time_param_sel(time_param_sel),
    .time_value    (time_value),
    .interval      (interval),
    .start_timer   (start_timer),
    .expired       (expired),
    .one_hz_enable (one_hz_enable),
    .remaining     (remaining)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic start(input logic [1:0] iv);
    interval    = iv;
    start_timer = 1'b1;
    step();
    start_timer = 1'b0;
  endtask

  task automatic write_time(input logic [1:0] sel, input logic [3:0] val);
    time_param_sel = sel;
    time_value     = val;
    reprogram      = 1'b1;
    step();
    reprogram = 1'b0;
  endtask

  task automatic test_reset();
    int exp_tick;
    // reset must beat a coincident write and start
    reprogram = 1'b1; time_param_sel = 2'b00; time_value = 4'd2;
    start_timer = 1'b1; interval = 2'b01;
    do_reset();
    reprogram = 1'b0; start_timer = 1'b0;
    total++;
    if (remaining !== 4'd0 || expired !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got rem=%0d exp=%0b expected rem=0 exp=0", remaining, expired);
    end
    total++;
    if (one_hz_enable !== 1'b0) begin
      bad++;
      $display("FAIL reset_tick: got %0b expected 0", one_hz_enable);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_tick = ((k % 4) == 3) ? 1 : 0;
      total++;
      if (one_hz_enable !== 1'(exp_tick) || remaining !== 4'd0 || expired !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle_tick k=%0d: got tick=%0b rem=%0d exp=%0b expected tick=%0d rem=0 exp=0",
                 k, one_hz_enable, remaining, expired, exp_tick);
      end
    end
    start(2'b00);
    total++;
    if (remaining !== 4'd6) begin bad++; $display("FAIL default_arm: got %0d expected 6", remaining); end
    start(2'b01);
    total++;
    if (remaining !== 4'd8) begin bad++; $display("FAIL default_driver: got %0d expected 8", remaining); end
    start(2'b10);
    total++;
    if (remaining !== 4'd15) begin bad++; $display("FAIL default_passenger: got %0d expected 15", remaining); end
    start(2'b11);
    total++;
    if (remaining !== 4'd10) begin bad++; $display("FAIL default_alarm: got %0d expected 10", remaining); end
  endtask

  task automatic test_driver();
    int exp_rem;
    do_reset();
    start(2'b01);
    total++;
    if (remaining !== 4'd8 || expired !== 1'b0) begin
      bad++;
      $display("FAIL driver_load: got rem=%0d exp=%0b expected rem=8 exp=0", remaining, expired);
    end
    for (int k = 1; k <= 34; k++) begin
      step();
      exp_rem = (k < 32) ? 8 - k / 4 : 0;
      total++;
      if (remaining !== 4'(exp_rem) || expired !== (k == 32)) begin
        bad++;
        $display("FAIL driver_count k=%0d: got rem=%0d exp=%0b expected rem=%0d exp=%0b",
                 k, remaining, expired, exp_rem, (k == 32));
      end
      total++;
      if (k < 32 && one_hz_enable !== ((k % 4) == 3)) begin
        bad++;
        $display("FAIL driver_tick k=%0d: got %0b expected %0b", k, one_hz_enable, ((k % 4) == 3));
      end
    end
  endtask

  task automatic test_reprogram_alarm();
    int exp_rem;
    write_time(2'b11, 4'd3);
    total++;
    if (remaining !== 4'd0 || expired !== 1'b0) begin
      bad++;
      $display("FAIL alarm_write_idle: got rem=%0d exp=%0b expected rem=0 exp=0", remaining, expired);
    end
    start(2'b11);
    total++;
    if (remaining !== 4'd3) begin bad++; $display("FAIL alarm_load: got %0d expected 3", remaining); end
    for (int k = 1; k <= 14; k++) begin
      step();
      exp_rem = (k < 12) ? 3 - k / 4 : 0;
      total++;
      if (remaining !== 4'(exp_rem) || expired !== (k == 12)) begin
        bad++;
        $display("FAIL alarm_count k=%0d: got rem=%0d exp=%0b expected rem=%0d exp=%0b",
                 k, remaining, expired, exp_rem, (k == 12));
      end
    end
    start(2'b00);
    total++;
    if (remaining !== 4'd6) begin bad++; $display("FAIL alarm_other_arm: got %0d expected 6", remaining); end
    start(2'b01);
    total++;
    if (remaining !== 4'd8) begin bad++; $display("FAIL alarm_other_driver: got %0d expected 8", remaining); end
    start(2'b10);
    total++;
    if (remaining !== 4'd15) begin bad++; $display("FAIL alarm_other_pass: got %0d expected 15", remaining); end
  endtask

  task automatic test_zero_value();
    write_time(2'b00, 4'd0);
    start(2'b00);
    total++;
    if (remaining !== 4'd1) begin bad++; $display("FAIL zero_load: got %0d expected 1", remaining); end
    for (int k = 1; k <= 6; k++) begin
      step();
      total++;
      if (remaining !== ((k < 4) ? 4'd1 : 4'd0) || expired !== (k == 4)) begin
        bad++;
        $display("FAIL zero_count k=%0d: got rem=%0d exp=%0b expected rem=%0d exp=%0b",
                 k, remaining, expired, (k < 4) ? 1 : 0, (k == 4));
      end
    end
  endtask

  task automatic test_restart();
    int exp_rem;
    do_reset();
    start(2'b00);
    for (int k = 1; k <= 9; k++) begin
      step();
      total++;
      if (remaining !== 4'(6 - k / 4) || expired !== 1'b0) begin
        bad++;
        $display("FAIL restart_first k=%0d: got rem=%0d exp=%0b expected rem=%0d exp=0",
                 k, remaining, expired, 6 - k / 4);
      end
    end
    start(2'b01);
    total++;
    if (remaining !== 4'd8 || expired !== 1'b0) begin
      bad++;
      $display("FAIL restart_load: got rem=%0d exp=%0b expected rem=8 exp=0", remaining, expired);
    end
    for (int k = 1; k <= 34; k++) begin
      step();
      exp_rem = (k < 32) ? 8 - k / 4 : 0;
      total++;
      if (remaining !== 4'(exp_rem) || expired !== (k == 32)) begin
        bad++;
        $display("FAIL restart_count k=%0d: got rem=%0d exp=%0b expected rem=%0d exp=%0b",
                 k, remaining, expired, exp_rem, (k == 32));
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_rem;
    do_reset();
    start(2'b00);
    for (int k = 1; k <= 23; k++) step();
    // start lands on the terminal tick of the arm count
    start(2'b11);
    total++;
    if (remaining !== 4'd10 || expired !== 1'b0) begin
      bad++;
      $display("FAIL b2b_start_on_terminal: got rem=%0d exp=%0b expected rem=10 exp=0", remaining, expired);
    end
    for (int k = 1; k <= 40; k++) begin
      step();
      exp_rem = (k < 40) ? 10 - k / 4 : 0;
      total++;
      if (remaining !== 4'(exp_rem) || expired !== (k == 40)) begin
        bad++;
        $display("FAIL b2b_alarm_count k=%0d: got rem=%0d exp=%0b expected rem=%0d exp=%0b",
                 k, remaining, expired, exp_rem, (k == 40));
      end
    end
    start(2'b00);
    total++;
    if (remaining !== 4'd6 || expired !== 1'b0) begin
      bad++;
      $display("FAIL b2b_start_in_done: got rem=%0d exp=%0b expected rem=6 exp=0", remaining, expired);
    end
    for (int k = 1; k <= 23; k++) step();
    write_time(2'b10, 4'd7);
    total++;
    if (remaining !== 4'd0 || expired !== 1'b0) begin
      bad++;
      $display("FAIL b2b_write_on_terminal: got rem=%0d exp=%0b expected rem=0 exp=0", remaining, expired);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      total++;
      if (remaining !== 4'd0 || expired !== 1'b0) begin
        bad++;
        $display("FAIL b2b_after_write k=%0d: got rem=%0d exp=%0b expected rem=0 exp=0", k, remaining, expired);
      end
    end
    start(2'b10);
    total++;
    if (remaining !== 4'd7) begin bad++; $display("FAIL b2b_written_pass: got %0d expected 7", remaining); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start(2'b01);
    for (int k = 1; k <= 4; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (remaining !== 4'd0 || expired !== 1'b0) begin
      bad++;
      $display("FAIL midreset_abort: got rem=%0d exp=%0b expected rem=0 exp=0", remaining, expired);
    end
    for (int k = 1; k <= 40; k++) begin
      step();
      total++;
      if (remaining !== 4'd0 || expired !== 1'b0) begin
        bad++;
        $display("FAIL midreset_idle k=%0d: got rem=%0d exp=%0b expected rem=0 exp=0", k, remaining, expired);
      end
    end
    time_param_sel = 2'b10; time_value = 4'd5; reprogram = 1'b1;
    interval = 2'b10; start_timer = 1'b1;
    step();
    reprogram = 1'b0; start_timer = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) step();
      total++;
      if (remaining !== 4'd0 || expired !== 1'b0) begin
        bad++;
        $display("FAIL midreset_start_ignored k=%0d: got rem=%0d exp=%0b expected rem=0 exp=0",
                 k, remaining, expired);
      end
    end
    start(2'b10);
    total++;
    if (remaining !== 4'd5) begin bad++; $display("FAIL midreset_written_pass: got %0d expected 5", remaining); end
  endtask

  initial begin
    reset = 1'b1; reprogram = 1'b0; time_param_sel = 2'b00; time_value = 4'd0;
    interval = 2'b00; start_timer = 1'b0;
    step();
    test_reset();
    test_driver();
    test_reprogram_alarm();
    test_zero_value();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
